dm_scan_checker: RTL and testbench

- Hardware result checker for the single-cycle CPU. It reads Data Memory, which the `top` core writes.
- On `start`, it walks a window of DM words, one word per cycle. Each word is compared against a golden-word port.
- It reports pass/fail, the mismatch count, and the first failing index and data.
- It sits beside DM. It drives the DM read port while the core is halted or parked.

---
 rtl/dm_scan_checker.sv | 138 +++++++++++++
 tb/tb_dm_scan_checker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dm_scan_checker.sv
// Walks a window of Data Memory one word per cycle and compares each word
// against a golden-word port, reporting pass/fail, mismatch count and first failure.
module dm_scan_checker #(
  parameter int bit_size = 32,
  parameter int mem_size = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [mem_size-1:0] base_addr,
  input  logic [mem_size-1:0] word_count,
  output logic [mem_size-1:0] DM_Address,
  output logic                DM_enable,
  output logic [bit_size-1:0] DM_Write_Data,
  input  logic [bit_size-1:0] DM_Read_Data,
  output logic [mem_size-1:0] gold_index,
  input  logic [bit_size-1:0] gold_data,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [mem_size-1:0] err_count,
  output logic [mem_size-1:0] first_err_idx,
  output logic [bit_size-1:0] first_err_data
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [mem_size-1:0] ZERO_M = {mem_size{1'b0}};
  localparam logic [mem_size-1:0] ONE_M  = {{(mem_size-1){1'b0}}, 1'b1};
  localparam logic [mem_size-1:0] ALL1_M = {mem_size{1'b1}};

  logic [1:0]          r_state;
  logic [mem_size-1:0] r_count;
  logic [mem_size-1:0] r_dm_addr;
  logic [mem_size-1:0] r_gold_index;
  logic                r_cmp_valid;
  logic [mem_size-1:0] r_cmp_idx;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic [mem_size-1:0] r_err_count;
  logic [mem_size-1:0] r_first_err_idx;
  logic [bit_size-1:0] r_first_err_data;

  logic w_mismatch;

  // Read data arrives one cycle after its address, so the compare runs a cycle behind the issue.
  assign w_mismatch = r_cmp_valid && (DM_Read_Data != gold_data);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= S_IDLE;
      r_count          <= ZERO_M;
      r_dm_addr        <= ZERO_M;
      r_gold_index     <= ZERO_M;
      r_cmp_valid      <= 1'b0;
      r_cmp_idx        <= ZERO_M;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b1;
      r_err_count      <= ZERO_M;
      r_first_err_idx  <= ZERO_M;
      r_first_err_data <= {bit_size{1'b0}};
    end else begin
      r_done      <= 1'b0;
      r_cmp_valid <= 1'b0;
      r_cmp_idx   <= r_gold_index;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_count          <= word_count;
            r_err_count      <= ZERO_M;
            r_first_err_idx  <= ZERO_M;
            r_first_err_data <= {bit_size{1'b0}};
            r_pass           <= 1'b1;
            if (word_count == ZERO_M) begin
              // Empty window: no issue cycles, address outputs keep their old value.
              r_state <= S_FINISH;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state      <= S_ISSUE;
              r_busy       <= 1'b1;
              r_dm_addr    <= base_addr;
              r_gold_index <= ZERO_M;
            end
          end
        end
        S_ISSUE: begin
          r_cmp_valid <= 1'b1;
          if (r_gold_index == (r_count - ONE_M)) begin
            r_state <= S_DRAIN;
          end else begin
            r_dm_addr    <= r_dm_addr + ONE_M;
            r_gold_index <= r_gold_index + ONE_M;
          end
        end
        S_DRAIN: begin
          r_state <= S_FINISH;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
      if (w_mismatch) begin
        r_pass <= 1'b0;
        if (r_err_count != ALL1_M) begin
          r_err_count <= r_err_count + ONE_M;
        end
        if (r_err_count == ZERO_M) begin
          r_first_err_idx  <= r_cmp_idx;
          r_first_err_data <= DM_Read_Data;
        end
      end
    end
  end

  assign DM_Address     = r_dm_addr;
  assign gold_index     = r_gold_index;
  assign DM_enable      = 1'b0;
  assign DM_Write_Data  = {bit_size{1'b0}};
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_count      = r_err_count;
  assign first_err_idx  = r_first_err_idx;
  assign first_err_data = r_first_err_data;

endmodule

// File: tb/tb_dm_scan_checker.sv
// Directed bench for dm_scan_checker: a DM and golden table with one-cycle read
// latency, a vector table for plain scans, and sequences for the multi-cycle cases.
module tb_dm_scan_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = 16'h0000;
  logic [15:0] word_count = 16'h0000;
  logic [15:0] DM_Address;
  logic        DM_enable;
  logic [31:0] DM_Write_Data;
  logic [31:0] DM_Read_Data;
  logic [15:0] gold_index;
  logic [31:0] gold_data;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;
  logic [15:0] first_err_idx;
  logic [31:0] first_err_data;

  logic [31:0] dm   [0:65535];
  logic [31:0] gold [0:15];
  logic [31:0] dm_rd = 32'h0;
  logic [31:0] gold_rd = 32'h0;

  int n_checks = 0;
  int n_pass = 0;
  int en_seen = 0;
  int lat;
  int ndone;
  logic [15:0] cap_addr [0:63];
  logic [15:0] cap_idx  [0:63];

  typedef struct {
    logic [15:0] base;
    logic [15:0] cnt;
    int          lat;
    logic        pass;
    logic [15:0] err;
    logic [15:0] fi;
    logic [31:0] fd;
  } vec_t;
  vec_t tbl [0:2];

  dm_scan_checker #(.bit_size(32), .mem_size(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .DM_Address(DM_Address), .DM_enable(DM_enable), .DM_Write_Data(DM_Write_Data),
    .DM_Read_Data(DM_Read_Data), .gold_index(gold_index), .gold_data(gold_data),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_data(first_err_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    dm_rd   <= dm[DM_Address];
    gold_rd <= gold[gold_index[3:0]];
  end
  assign DM_Read_Data = dm_rd;
  assign gold_data    = gold_rd;

  always @(negedge clk) begin
    if (DM_enable !== 1'b0 || DM_Write_Data !== 32'h0) en_seen++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One scan; optionally pulses another start at negedge inj_t (1 = first cycle after start).
  task automatic run_scan(input logic [15:0] b, input logic [15:0] c, input int inj_t);
    lat = -1;
    ndone = 0;
    @(negedge clk);
    base_addr = b; word_count = c; start = 1'b1;
    for (int t = 1; t <= int'(c) + 8; t++) begin
      @(negedge clk);
      if (start) begin
        start = 1'b0; base_addr = 16'h5555; word_count = 16'h0003;
      end
      if (t <= 64) begin
        cap_addr[t-1] = DM_Address;
        cap_idx[t-1]  = gold_index;
      end
      if (done) begin
        ndone++;
        if (lat < 0) lat = t;
      end
      if (t == inj_t) begin
        start = 1'b1; base_addr = 16'd10; word_count = 16'd2;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_a;
    int d;
    for (int i = 0; i < 65536; i++) dm[i] = 32'h0;
    for (int i = 0; i < 16; i++) gold[i] = 32'hC0DE_0000 + 32'(i);
    for (int i = 0; i < 10; i++) dm[i] = gold[i];
    for (int i = 0; i < 5; i++) dm[10+i] = gold[i];
    dm[16'hFFFE] = gold[0];
    dm[16'hFFFF] = gold[1];

    tbl[0] = '{16'd0,     16'd10, 12, 1'b1, 16'd0, 16'd0, 32'h0};
    tbl[1] = '{16'd10,    16'd5,  7,  1'b1, 16'd0, 16'd0, 32'h0};
    // dm[0] holds gold[0], so the wrapped third word misses against gold[2].
    tbl[2] = '{16'hFFFE,  16'd3,  5,  1'b0, 16'd1, 16'd2, 32'hC0DE_0000};

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_pass", 32'(pass), 32'h1);
    check("rst_err", 32'(err_count), 32'h0);
    check("rst_addr", 32'(DM_Address), 32'h0);
    check("rst_gidx", 32'(gold_index), 32'h0);
    check("rst_fidx", 32'(first_err_idx), 32'h0);
    check("rst_fdata", first_err_data, 32'h0);
    rst = 1'b1;

    for (int v = 0; v < 3; v++) begin
      run_scan(tbl[v].base, tbl[v].cnt, 0);
      check("tbl_lat", 32'(lat), 32'(tbl[v].lat));
      check("tbl_ndone", 32'(ndone), 32'h1);
      check("tbl_pass", 32'(pass), 32'(tbl[v].pass));
      check("tbl_err", 32'(err_count), 32'(tbl[v].err));
      check("tbl_fidx", 32'(first_err_idx), 32'(tbl[v].fi));
      check("tbl_fdata", first_err_data, tbl[v].fd);
      for (int k = 0; k < int'(tbl[v].cnt); k++) begin
        exp_a = tbl[v].base + 16'(k);
        check("tbl_addr", 32'(cap_addr[k]), 32'(exp_a));
        check("tbl_gidx", 32'(cap_idx[k]), 32'(k));
      end
    end

    dm[3] = 32'hDEAD_BEEF;
    dm[7] = 32'h0000_0000;
    run_scan(16'd0, 16'd10, 0);
    check("mm_lat", 32'(lat), 32'd12);
    check("mm_pass", 32'(pass), 32'h0);
    check("mm_err", 32'(err_count), 32'd2);
    check("mm_fidx", 32'(first_err_idx), 32'd3);
    check("mm_fdata", first_err_data, 32'hDEAD_BEEF);

    run_scan(16'h0020, 16'd0, 0);
    check("zero_lat", 32'(lat), 32'd1);
    check("zero_ndone", 32'(ndone), 32'h1);
    check("zero_pass", 32'(pass), 32'h1);
    check("zero_err", 32'(err_count), 32'h0);
    check("zero_fidx", 32'(first_err_idx), 32'h0);
    check("zero_addr_hold", 32'(DM_Address), 32'd9);
    check("zero_gidx_hold", 32'(gold_index), 32'd9);

    run_scan(16'd0, 16'd10, 3);
    check("busy_lat", 32'(lat), 32'd12);
    check("busy_ndone", 32'(ndone), 32'h1);
    check("busy_err", 32'(err_count), 32'd2);
    check("busy_fidx", 32'(first_err_idx), 32'd3);

    run_scan(16'd10, 16'd5, 7);
    check("fin_lat", 32'(lat), 32'd7);
    check("fin_ndone", 32'(ndone), 32'h1);
    check("fin_pass", 32'(pass), 32'h1);

    @(negedge clk);
    base_addr = 16'd0; word_count = 16'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_pass", 32'(pass), 32'h0);
    check("mid_err", 32'(err_count), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_pass", 32'(pass), 32'h1);
    check("arst_err", 32'(err_count), 32'h0);
    check("arst_fidx", 32'(first_err_idx), 32'h0);
    d = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b1;
      if (done) d++;
    end
    check("arst_nodone", 32'(d), 32'h0);

    run_scan(16'd0, 16'd10, 0);
    check("fresh_lat", 32'(lat), 32'd12);
    check("fresh_err", 32'(err_count), 32'd2);
    check("fresh_fdata", first_err_data, 32'hDEAD_BEEF);
    check("fresh_addr0", 32'(cap_addr[0]), 32'h0);
    check("fresh_addr9", 32'(cap_addr[9]), 32'd9);

    check("dm_enable_never", 32'(en_seen), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
